snurisc_mem_arbiter: RTL
========================

Name: snurisc_mem_arbiter

Overview:
- Shares one unified memory port between three requesters of the snurisc core:
  - the front-end loader, used to initialise I$/D$ contents before run and to dump them after;
  - the data-memory stage (dmem);
  - the instruction-fetch stage (imem).
- Sits between the snurisc core and the single memory model in the testbench/top.
- Serialises transactions with exactly one outstanding at a time.
- Includes a response-timeout watchdog.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; the byte-strobe width is DW/8.
- TIMEOUT, 255, maximum cycles spent in WAIT before abort; 0 disables the watchdog; maximum value 65535.

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_reset  in  1  asynchronous active-low reset.
- Per requester, with prefix P in {ld, dm, im}:
  - i_P_req  in  1  request.
  - i_P_we  in  1  write enable.
  - i_P_addr  in  AW  address.
  - i_P_wdata  in  DW  write data.
  - i_P_wstrb  in  DW/8  byte strobes.
  - o_P_gnt  out  1  grant.
  - o_P_rvalid  out  1  response valid.
  - o_P_rdata  out  DW  response data.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  AW  memory address.
- o_mem_wdata  out  DW  memory write data.
- o_mem_wstrb  out  DW/8  memory byte strobes.
- i_mem_ready  in  1  memory accepted request.
- i_mem_rvalid  in  1  memory response valid; asserted for both reads and writes.
- i_mem_rdata  in  DW  memory read data.
- o_busy  out  1  state != IDLE.
- o_err  out  1  sticky: a timeout or a spurious response has occurred.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT.
- Registers: owner[1:0], latched request fields, rr_last (last winner between dm/im), wdog counter (16 bits), err.
- Reset (i_reset=0, asynchronous) forces all of the following, regardless of the operation in flight:
  - state IDLE; owner none; rr_last=im, so dm wins the first tie;
  - wdog=0; err=0;
  - all o_* outputs 0.
- IDLE:
  - Winner selection: ld has strict priority; otherwise dm vs im round-robin, where the side not equal to rr_last wins a tie, and a single requester always wins.
  - o_P_gnt for the winner is asserted combinationally in this cycle and is 1 for exactly one cycle.
  - On the clock edge: latch the winner's we/addr/wdata/wstrb, set owner, update rr_last (only when the winner is dm or im), go to ISSUE.
  - Requesters hold their fields stable until they see gnt, and may drop req afterwards.
  - Nothing happens if no request is present.
- ISSUE:
  - o_mem_req=1 and the o_mem_* outputs are driven from the latched registers.
  - Hold until i_mem_ready=1, then go to WAIT with wdog=0.
  - The watchdog does not run in ISSUE.
- WAIT:
  - o_mem_req=0; wdog increments every cycle.
  - On i_mem_rvalid=1: o_owner_rvalid=1 and o_owner_rdata=i_mem_rdata in that same cycle (combinational path), then go to IDLE.
  - Timeout: if TIMEOUT!=0 and wdog==TIMEOUT-1 with no rvalid, assert o_owner_rvalid=1 with rdata=0, set err, go to IDLE.
  - rvalid arriving in the same cycle as the timeout wins; err stays unchanged in that case.
- i_mem_rvalid in IDLE or ISSUE is spurious: it is ignored (no requester rvalid) and sets err.
- o_P_rdata is 0 whenever o_P_rvalid is 0.
- Minimum latency, read or write:
  - req seen in IDLE at cycle N;
  - mem_req at N+1 (ready at N+1);
  - rvalid earliest at N+2, returned to the requester at N+2;
  - next grant possible at N+3.
- Throughput: one transaction per 3 cycles maximum.
- Requests arriving in ISSUE/WAIT wait without a grant; no queueing beyond each requester's held req.
- A ld request arriving mid-transaction does not preempt; it wins at the next IDLE.
- wdog saturates and does not wrap.

Test Plan:
- Single im read:
  - Stimulus: im_req at cycle 0, addr=0x100; memory ready immediately, rvalid one cycle later with 0xDEADBEEF.
  - Required response: im_gnt at c0, mem_req at c1 with addr 0x100, im_rvalid with 0xDEADBEEF at c2, busy low at c3.
- dm/im contention, both requesting continuously after reset:
  - Required response: grant order dm, im, dm, im.
  - Required response: each rvalid goes only to its owner; no two gnts share a cycle.
- Loader priority:
  - Stimulus: ld, dm and im all request together; ld issues a write with wstrb=4'b0011.
  - Required response: ld is granted first.
  - Required response: mem_we=1 and wstrb=0011 are held until ready.
  - Required response: then dm is granted.
- Backpressure:
  - Stimulus: i_mem_ready held low for 5 cycles.
  - Required response: o_mem_req and its fields stay stable for all 5 cycles.
  - Required response: wdog stays at 0, with no timeout even with TIMEOUT=4.
- Timeout:
  - Stimulus: TIMEOUT=4, no rvalid.
  - Required response: owner rvalid with rdata=0 at the 4th WAIT cycle, err=1, return to IDLE.
  - Required response: a later normal read still works and err stays 1.
- Reset mid-WAIT:
  - Stimulus: i_reset pulled low asynchronously in the middle of WAIT.
  - Required response: outputs are 0 immediately, without waiting for a clock edge.
  - Stimulus: a late i_mem_rvalid arrives after reset release.
  - Required response: err=1 and no requester sees rvalid.

Source files
------------

// File: rtl/snurisc_mem_arbiter.sv
// rtl/snurisc_mem_arbiter.sv - three-way arbiter (loader, dmem, imem) onto one memory port
// One transaction outstanding at a time, with a response watchdog and a sticky error flag.
module snurisc_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_ld_req,
  input  logic            i_ld_we,
  input  logic [AW-1:0]   i_ld_addr,
  input  logic [DW-1:0]   i_ld_wdata,
  input  logic [DW/8-1:0] i_ld_wstrb,
  output logic            o_ld_gnt,
  output logic            o_ld_rvalid,
  output logic [DW-1:0]   o_ld_rdata,
  input  logic            i_dm_req,
  input  logic            i_dm_we,
  input  logic [AW-1:0]   i_dm_addr,
  input  logic [DW-1:0]   i_dm_wdata,
  input  logic [DW/8-1:0] i_dm_wstrb,
  output logic            o_dm_gnt,
  output logic            o_dm_rvalid,
  output logic [DW-1:0]   o_dm_rdata,
  input  logic            i_im_req,
  input  logic            i_im_we,
  input  logic [AW-1:0]   i_im_addr,
  input  logic [DW-1:0]   i_im_wdata,
  input  logic [DW/8-1:0] i_im_wstrb,
  output logic            o_im_gnt,
  output logic            o_im_rvalid,
  output logic [DW-1:0]   o_im_rdata,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [DW/8-1:0] o_mem_wstrb,
  input  logic            i_mem_ready,
  input  logic            i_mem_rvalid,
  input  logic [DW-1:0]   i_mem_rdata,
  output logic            o_busy,
  output logic            o_err
);

  localparam int          SW        = DW / 8;
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);
  localparam logic        WDOG_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_LD, OWN_DM, OWN_IM} owner_e;

  state_e          state_q;
  owner_e          owner_q;
  logic            rr_last_q;  // 1: imem won last, so dmem wins the next tie
  logic [15:0]     wdog_q;
  logic            err_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;

  owner_e          win;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [SW-1:0]   sel_wstrb;
  logic            in_issue;
  logic            in_wait;
  logic            wait_tmo;
  logic            rsp_fire;
  logic [DW-1:0]   rsp_data;

  always_comb begin
    win       = OWN_NONE;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    if (state_q == S_IDLE && i_reset) begin
      if (i_ld_req)                              win = OWN_LD;
      else if (i_dm_req && (!i_im_req || rr_last_q)) win = OWN_DM;
      else if (i_im_req)                         win = OWN_IM;
    end
    case (win)
      OWN_LD: begin
        sel_we = i_ld_we; sel_addr = i_ld_addr; sel_wdata = i_ld_wdata; sel_wstrb = i_ld_wstrb;
      end
      OWN_DM: begin
        sel_we = i_dm_we; sel_addr = i_dm_addr; sel_wdata = i_dm_wdata; sel_wstrb = i_dm_wstrb;
      end
      OWN_IM: begin
        sel_we = i_im_we; sel_addr = i_im_addr; sel_wdata = i_im_wdata; sel_wstrb = i_im_wstrb;
      end
      default: ;
    endcase
  end

  assign o_ld_gnt = (win == OWN_LD);
  assign o_dm_gnt = (win == OWN_DM);
  assign o_im_gnt = (win == OWN_IM);

  assign in_issue = (state_q == S_ISSUE);
  assign in_wait  = (state_q == S_WAIT);
  // A response in the timeout cycle takes precedence over the abort.
  assign wait_tmo = WDOG_EN && (wdog_q == WDOG_LAST) && !i_mem_rvalid;
  assign rsp_fire = in_wait && (i_mem_rvalid || wait_tmo);
  assign rsp_data = i_mem_rvalid ? i_mem_rdata : '0;

  assign o_ld_rvalid = rsp_fire && (owner_q == OWN_LD);
  assign o_dm_rvalid = rsp_fire && (owner_q == OWN_DM);
  assign o_im_rvalid = rsp_fire && (owner_q == OWN_IM);
  assign o_ld_rdata  = o_ld_rvalid ? rsp_data : '0;
  assign o_dm_rdata  = o_dm_rvalid ? rsp_data : '0;
  assign o_im_rdata  = o_im_rvalid ? rsp_data : '0;

  assign o_mem_req   = in_issue;
  assign o_mem_we    = in_issue && we_q;
  assign o_mem_addr  = in_issue ? addr_q  : '0;
  assign o_mem_wdata = in_issue ? wdata_q : '0;
  assign o_mem_wstrb = in_issue ? wstrb_q : '0;
  assign o_busy      = (state_q != S_IDLE);
  assign o_err       = err_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_NONE;
      rr_last_q <= 1'b1;
      wdog_q    <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_mem_rvalid) err_q <= 1'b1;
          if (win != OWN_NONE) begin
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            wstrb_q <= sel_wstrb;
            owner_q <= win;
            if (win == OWN_DM) rr_last_q <= 1'b0;
            if (win == OWN_IM) rr_last_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_mem_rvalid) err_q <= 1'b1;
          if (i_mem_ready) begin
            wdog_q  <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_mem_rvalid) begin
            owner_q <= OWN_NONE;
            state_q <= S_IDLE;
          end else if (wait_tmo) begin
            err_q   <= 1'b1;
            owner_q <= OWN_NONE;
            state_q <= S_IDLE;
          end else if (wdog_q != 16'hFFFF) begin
            wdog_q  <= wdog_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
